// File: rtl/gpio_key_in_if.sv
// rtl/gpio_key_in_if.sv - register bus bundle for the key input block
interface gpio_key_in_if;
  logic        wr_en_i;
  logic [31:0] wr_addr_i;
  logic [31:0] wr_data_i;
  logic [31:0] rd_addr_i;
  logic [31:0] rd_data_o;

  modport master (
    output wr_en_i,
    output wr_addr_i,
    output wr_data_i,
    output rd_addr_i,
    input  rd_data_o
  );

  modport slave (
    input  wr_en_i,
    input  wr_addr_i,
    input  wr_data_i,
    input  rd_addr_i,
    output rd_data_o
  );
endinterface

// File: rtl/gpio_key_in.sv
// rtl/gpio_key_in.sv - debounced active-low key inputs with edge status, press counter and irq
module gpio_key_in #(
  parameter int unsigned DEBOUNCE_CNT = 1000000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  gpio_key_in_if.slave bus,
  input  logic [3:0]   key_pins_i,
  output logic         irq_o
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [31:0]      CTRL_MASK = 32'h0000_0FF1;
  localparam logic [3:0]       A_CTRL    = 4'h0;
  localparam logic [3:0]       A_DATA    = 4'h4;
  localparam logic [3:0]       A_STAT    = 4'h8;
  localparam logic [3:0]       A_CNT     = 4'hC;

  logic [3:0]       sync_q1;
  logic [3:0]       sync_q2;
  logic [CNT_W-1:0] db_cnt [4];
  logic [3:0]       stable;
  logic [3:0]       db_flip;
  logic [3:0]       press_pulse;
  logic [3:0]       rel_pulse;
  logic [2:0]       press_num;

  logic [31:0]      key_ctrl;
  logic [7:0]       key_stat;
  logic [15:0]      key_cnt;
  logic [31:0]      rd_addr_reg;

  logic             wr_ctrl;
  logic             wr_stat;
  logic             wr_cnt;
  logic [7:0]       stat_clr;
  logic             irq_next;

  // Upper address bits must be zero, so aliases such as 0x10 behave as unmapped
  function automatic logic reg_hit(input logic [31:0] addr, input logic [3:0] offset);
    return (addr[31:4] == 28'h0) && (addr[3:0] == offset);
  endfunction

  // Two-flop synchroniser; pins are inverted on entry so the flops carry pressed=1 and reset to released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= ~key_pins_i;
      sync_q2 <= sync_q1;
    end
  end

  // A key flips once its synced level has disagreed with stable for DEBOUNCE_CNT cycles in a row
  always_comb begin
    db_flip = '0;
    for (int i = 0; i < 4; i++) begin
      db_flip[i] = (sync_q2[i] != stable[i]) && (db_cnt[i] == CNT_LAST);
    end
  end

  assign press_pulse = db_flip & ~stable;
  assign rel_pulse   = db_flip & stable;
  assign press_num   = 3'(press_pulse[0]) + 3'(press_pulse[1]) +
                       3'(press_pulse[2]) + 3'(press_pulse[3]);

  // Per-key debounce counters and the accepted (stable) key levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
      stable <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_q2[i] == stable[i] || db_flip[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
      stable <= stable ^ db_flip;
    end
  end

  assign wr_ctrl  = bus.wr_en_i && reg_hit(bus.wr_addr_i, A_CTRL);
  assign wr_stat  = bus.wr_en_i && reg_hit(bus.wr_addr_i, A_STAT);
  assign wr_cnt   = bus.wr_en_i && reg_hit(bus.wr_addr_i, A_CNT);
  assign stat_clr = wr_stat ? bus.wr_data_i[7:0] : 8'h0;

  // Control, W1C status (a new event beats a same-cycle clear) and press counter (write clears, presses still add)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_ctrl <= '0;
      key_stat <= '0;
      key_cnt  <= '0;
    end else begin
      if (wr_ctrl) begin
        key_ctrl <= bus.wr_data_i & CTRL_MASK;
      end
      key_stat <= (key_stat & ~stat_clr) | {rel_pulse, press_pulse};
      key_cnt  <= (wr_cnt ? 16'h0 : key_cnt) + {13'h0, press_num};
    end
  end

  assign irq_next = key_ctrl[0] &
                    (|((key_stat[3:0] & key_ctrl[7:4]) | (key_stat[7:4] & key_ctrl[11:8])));

  // Registered interrupt and read address (read data follows one cycle after the address)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_o       <= 1'b0;
      rd_addr_reg <= '0;
    end else begin
      irq_o       <= irq_next;
      rd_addr_reg <= bus.rd_addr_i;
    end
  end

  // Read mux on the registered address; unmapped locations return zero
  always_comb begin
    bus.rd_data_o = '0;
    if (reg_hit(rd_addr_reg, A_CTRL)) begin
      bus.rd_data_o = key_ctrl;
    end else if (reg_hit(rd_addr_reg, A_DATA)) begin
      bus.rd_data_o = {28'h0, stable};
    end else if (reg_hit(rd_addr_reg, A_STAT)) begin
      bus.rd_data_o = {24'h0, key_stat};
    end else if (reg_hit(rd_addr_reg, A_CNT)) begin
      bus.rd_data_o = {16'h0, key_cnt};
    end
  end

endmodule
